// File: rtl/dmem_addr_unit.sv
// Data-memory address unit: a {row, col} address register (MAR) with linear
// and field-wise update commands, plus a small word memory addressed by MAR.
// Reads complete one cycle after they are sampled; writes land at the edge.
//
// Command/response semantics: every command input is a level sampled on each
// rising clk edge while enable=1, so holding a command high for N cycles acts
// N times. There is no back-pressure. A read sampled at edge T returns
// rd_data with a single-cycle rd_valid pulse after edge T+1. Reads issued on
// consecutive edges produce rd_valid on consecutive cycles.
module dmem_addr_unit #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     mar_ld,
    input  logic [ROW_W+COL_W-1:0]   mar_in,
    input  logic                     mar_inc,
    input  logic                     col_inc,
    input  logic                     col_zero,
    input  logic                     row_inc,
    input  logic                     dmem_read,
    input  logic                     dmem_write,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [ROW_W+COL_W-1:0]   mar,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     wrap,
    output logic                     cmd_err
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;

    // Address register fields
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] mar_cur;

    // Status pulses
    logic              wrap_q, wrap_d;
    logic              cmd_err_q, cmd_err_d;

    // Read pipeline: stage 1 captures the word, stage 2 presents it
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Storage (not reset)
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;

    logic              field_cmd;

    assign mar_cur   = {row_q, col_q};
    assign field_cmd = row_inc | col_inc | col_zero;
    assign mem_we    = enable & dmem_write;

    // MAR next-state: load beats field commands, field commands beat mar_inc
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        wrap_d = 1'b0;
        if (enable) begin
            if (mar_ld) begin
                {row_d, col_d} = mar_in;
            end else if (field_cmd) begin
                if (row_inc) begin
                    row_d  = row_q + ROW_W'(1);
                    wrap_d = &row_q;
                end
                if (col_zero) begin
                    col_d = '0;
                end else if (col_inc) begin
                    col_d = col_q + COL_W'(1);
                end
            end else if (mar_inc) begin
                {row_d, col_d} = mar_cur + ADDR_W'(1);
                wrap_d         = &mar_cur;
            end
        end
    end

    // Conflict detection: any command that loses arbitration flags an error
    always_comb begin
        cmd_err_d = 1'b0;
        if (enable) begin
            cmd_err_d = (dmem_read & dmem_write)
                      | (mar_ld & (mar_inc | field_cmd))
                      | (col_zero & col_inc)
                      | (mar_inc & field_cmd);
        end
    end

    // Read path: a write in the same cycle drops the read; completion of an
    // already-captured read does not depend on enable
    always_comb begin
        rd_pend_d  = enable & dmem_read & ~dmem_write;
        rd_buf_d   = rd_buf_q;
        if (rd_pend_d) begin
            rd_buf_d = mem_q[mar_cur];
        end
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_data_q;
        if (rd_pend_q) begin
            rd_data_d = rd_buf_q;
        end
    end

    // Control and data registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q      <= '0;
            col_q      <= '0;
            wrap_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_buf_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            wrap_q     <= wrap_d;
            cmd_err_q  <= cmd_err_d;
            rd_pend_q  <= rd_pend_d;
            rd_buf_q   <= rd_buf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Memory write at the pre-update MAR
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mar_cur] <= wr_data;
        end
    end

    assign mar      = mar_cur;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wrap     = wrap_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_dmem_addr_unit.sv
// Bench for dmem_addr_unit: directed scenarios with literal expectations,
// then randomized commands checked every cycle against a behavioural model.
module tb_dmem_addr_unit;

    localparam int DATA_W = 16;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CN     = 1 << COL_W;
    localparam int RN     = 1 << ROW_W;

    // Clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic              enable, mar_ld, mar_inc, col_inc, col_zero, row_inc;
    logic              dmem_read, dmem_write;
    logic [ADDR_W-1:0] mar_in;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, wrap, cmd_err;

    dmem_addr_unit #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .mar_ld(mar_ld), .mar_in(mar_in), .mar_inc(mar_inc),
        .col_inc(col_inc), .col_zero(col_zero), .row_inc(row_inc),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .wr_data(wr_data),
        .mar(mar), .rd_data(rd_data), .rd_valid(rd_valid),
        .wrap(wrap), .cmd_err(cmd_err)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: integer row/col arithmetic, memory array, and an
    // expected-read queue holding the word owed by each accepted read
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] e_mar;
    logic [DATA_W-1:0] e_rd_data;
    logic              e_rd_valid, e_wrap, e_err;
    int                m_old, m_row, m_col, m_nxt;
    bit                m_wrap, m_err, m_field;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_mar      <= '0;
            e_rd_data  <= '0;
            e_rd_valid <= 1'b0;
            e_wrap     <= 1'b0;
            e_err      <= 1'b0;
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) begin
                e_rd_valid <= 1'b1;
                e_rd_data  <= exp_q.pop_front();
            end else begin
                e_rd_valid <= 1'b0;
            end
            e_wrap <= 1'b0;
            e_err  <= 1'b0;
            if (enable) begin
                m_old   = int'(e_mar);
                m_row   = m_old / CN;
                m_col   = m_old % CN;
                m_field = row_inc || col_inc || col_zero;
                m_wrap  = 1'b0;
                m_err   = (dmem_read && dmem_write) || (mar_ld && (mar_inc || m_field))
                       || (col_zero && col_inc) || (mar_inc && m_field);
                if (dmem_write) m_mem[m_old] = wr_data;
                else if (dmem_read) exp_q.push_back(m_mem[m_old]);
                if (mar_ld) begin
                    m_nxt = int'(mar_in);
                end else if (m_field) begin
                    m_wrap = row_inc && (m_row == RN - 1);
                    m_row  = (m_row + (row_inc ? 1 : 0)) % RN;
                    m_col  = col_zero ? 0 : (m_col + (col_inc ? 1 : 0)) % CN;
                    m_nxt  = m_row * CN + m_col;
                end else if (mar_inc) begin
                    m_wrap = (m_old == DEPTH - 1);
                    m_nxt  = (m_old + 1) % DEPTH;
                end else begin
                    m_nxt = m_old;
                end
                e_mar  <= ADDR_W'(m_nxt);
                e_wrap <= m_wrap;
                e_err  <= m_err;
            end
        end
    end

    // Compare process: every falling edge once checking is armed
    always @(negedge clk) begin
        if (chk_en) begin
            check("mar", 32'(mar), 32'(e_mar));
            check("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
            check("rd_data", 32'(rd_data), 32'(e_rd_data));
            check("wrap", 32'(wrap), 32'(e_wrap));
            check("cmd_err", 32'(cmd_err), 32'(e_err));
        end
    end

    // Driver tasks
    task automatic clear_cmds();
        enable = 1'b1; mar_ld = 1'b0; mar_inc = 1'b0; col_inc = 1'b0;
        col_zero = 1'b0; row_inc = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
        mar_in = '0; wr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_cmds();
    endtask

    task automatic load(input logic [ADDR_W-1:0] a);
        mar_ld = 1'b1; mar_in = a;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        clear_cmds();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_mar", 32'(mar), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Preload every word so all later reads have known data
        load(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            dmem_write = 1'b1; wr_data = 16'($urandom); mar_inc = 1'b1;
            tick();
        end
        check("preload_wrap", 32'(mar), 32'h00);

        // Write two words, read them back-to-back
        load(8'h00);
        dmem_write = 1'b1; wr_data = 16'hA5A5; tick();
        mar_inc = 1'b1; tick();
        dmem_write = 1'b1; wr_data = 16'h1234; tick();
        load(8'h00);
        dmem_read = 1'b1; mar_inc = 1'b1; tick();
        dmem_read = 1'b1; tick();
        check("b2b_valid0", 32'(rd_valid), 32'h1);
        check("b2b_data0", 32'(rd_data), 32'hA5A5);
        tick();
        check("b2b_valid1", 32'(rd_valid), 32'h1);
        check("b2b_data1", 32'(rd_data), 32'h1234);
        tick();
        check("b2b_idle", 32'(rd_valid), 32'h0);

        // Column wrap without carry; combined field commands
        load(8'h3F);
        col_inc = 1'b1; tick();
        check("col_wrap_mar", 32'(mar), 32'h30);
        check("col_wrap_nowrap", 32'(wrap), 32'h0);
        load(8'h35);
        col_zero = 1'b1; row_inc = 1'b1; tick();
        check("czero_rinc_mar", 32'(mar), 32'h40);

        // Full-address wrap and row wrap
        load(8'hFF);
        mar_inc = 1'b1; tick();
        check("inc_wrap_mar", 32'(mar), 32'h00);
        check("inc_wrap_pulse", 32'(wrap), 32'h1);
        tick();
        check("inc_wrap_once", 32'(wrap), 32'h0);
        load(8'hF2);
        row_inc = 1'b1; tick();
        check("row_wrap_mar", 32'(mar), 32'h02);
        check("row_wrap_pulse", 32'(wrap), 32'h1);

        // Read+write conflict: write wins, read dropped
        load(8'h10);
        dmem_read = 1'b1; dmem_write = 1'b1; wr_data = 16'hBEEF; tick();
        check("rw_err", 32'(cmd_err), 32'h1);
        dmem_read = 1'b1; tick();
        check("rw_no_valid", 32'(rd_valid), 32'h0);
        tick();
        check("rw_readback", 32'(rd_data), 32'hBEEF);

        // MAR command conflicts
        load(8'h21);
        mar_inc = 1'b1; col_inc = 1'b1; tick();
        check("inc_col_mar", 32'(mar), 32'h22);
        check("inc_col_err", 32'(cmd_err), 32'h1);
        mar_ld = 1'b1; mar_in = 8'h50; row_inc = 1'b1; tick();
        check("ld_row_mar", 32'(mar), 32'h50);
        check("ld_row_err", 32'(cmd_err), 32'h1);
        check("ld_no_wrap", 32'(wrap), 32'h0);

        // Read completes even when enable falls next cycle
        dmem_read = 1'b1; tick();
        enable = 1'b0; tick();
        check("en_fall_valid", 32'(rd_valid), 32'h1);

        // Mid-cycle reset cancels an in-flight read
        load(8'h33);
        dmem_read = 1'b1; tick();
        #1 reset_n = 1'b0;
        #1;
        check("rst_mar", 32'(mar), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        reset_n = 1'b1;
        tick();
        check("rst_cancel", 32'(rd_valid), 32'h0);

        // Disabled unit holds MAR
        load(8'h44);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b0; mar_inc = 1'b1; tick();
        end
        check("dis_hold", 32'(mar), 32'h44);

        // Randomized commands, occasional mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            mar_ld     = ($urandom_range(0, 9) == 0);
            mar_in     = 8'($urandom);
            mar_inc    = ($urandom_range(0, 3) == 0);
            col_inc    = ($urandom_range(0, 5) == 0);
            col_zero   = ($urandom_range(0, 7) == 0);
            row_inc    = ($urandom_range(0, 7) == 0);
            dmem_read  = ($urandom_range(0, 2) == 0);
            dmem_write = ($urandom_range(0, 3) == 0);
            wr_data    = 16'($urandom);
            tick();
            if ($urandom_range(0, 299) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
